// File: rtl/ifm_stream_buffer.sv
// IFM stream buffer: AXI-Stream slave feeding a first-word-fall-through FIFO that a
// downstream parser pops one word per input_req, with frame bookkeeping and sticky errors.
module ifm_stream_buffer #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_conv_pulse,
    input  logic [15:0]               cfg_frame_words,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    input  logic                      input_req,
    output logic [DATA_WIDTH-1:0]     fm,
    output logic                      fm_valid,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      frame_done,
    output logic                      underflow_err,
    output logic                      tlast_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FullLevel = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic [ADDR_W:0]       level_q;
    logic [15:0]           in_cnt_q;
    logic [15:0]           out_cnt_q;
    logic [15:0]           frame_words_q;
    logic                  frame_done_q;
    logic                  underflow_q;
    logic                  tlast_err_q;

    logic push;
    logic pop;
    logic last_beat;

    // tready depends on registered state only, so input_req never reaches it.
    assign s_axis_tready = (state_q == StRun) && (level_q != FullLevel)
                           && (in_cnt_q != frame_words_q);
    assign fm_valid      = (level_q != '0);
    assign fm            = fm_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level    = level_q;
    assign frame_done    = frame_done_q;
    assign underflow_err = underflow_q;
    assign tlast_err     = tlast_err_q;

    assign push      = s_axis_tvalid && s_axis_tready && !start_conv_pulse;
    assign pop       = input_req && fm_valid && !start_conv_pulse;
    assign last_beat = (in_cnt_q == frame_words_q - 16'd1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            frame_words_q <= '0;
            frame_done_q  <= 1'b0;
            underflow_q   <= 1'b0;
            tlast_err_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (start_conv_pulse) begin
                // New frame (or abort): flush and reload; a zero-length frame completes at once.
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                level_q       <= '0;
                in_cnt_q      <= '0;
                out_cnt_q     <= '0;
                frame_words_q <= cfg_frame_words;
                underflow_q   <= 1'b0;
                tlast_err_q   <= 1'b0;
                if (cfg_frame_words == 16'd0) begin
                    state_q      <= StIdle;
                    frame_done_q <= 1'b1;
                end else begin
                    state_q <= StRun;
                end
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    in_cnt_q <= in_cnt_q + 16'd1;
                    if (s_axis_tlast != last_beat) begin
                        tlast_err_q <= 1'b1;
                    end
                    if (in_cnt_q + 16'd1 == frame_words_q) begin
                        state_q <= StDrain;
                    end
                end
                if (pop) begin
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    out_cnt_q <= out_cnt_q + 16'd1;
                    if (state_q == StDrain && out_cnt_q + 16'd1 == frame_words_q) begin
                        frame_done_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                if (input_req && !fm_valid) begin
                    underflow_q <= 1'b1;
                end
                if (push && !pop) begin
                    level_q <= level_q + 1'b1;
                end else if (pop && !push) begin
                    level_q <= level_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifm_stream_buffer.sv
// Bench for ifm_stream_buffer: scenario tasks with inline checks plus a data scoreboard
// that records accepted beats and compares every popped head word in order.
module tb_ifm_stream_buffer;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_conv_pulse = 1'b0;
    logic [15:0]   cfg_frame_words = '0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          input_req = 1'b0;
    logic [DW-1:0] fm;
    logic          fm_valid;
    logic [3:0]    fifo_level;
    logic          frame_done;
    logic          underflow_err;
    logic          tlast_err;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_tag = 0;
    logic [DW-1:0] sb[$];

    ifm_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start_conv_pulse(start_conv_pulse),
        .cfg_frame_words(cfg_frame_words), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .input_req(input_req), .fm(fm), .fm_valid(fm_valid),
        .fifo_level(fifo_level), .frame_done(frame_done), .underflow_err(underflow_err),
        .tlast_err(tlast_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: inputs are stable at negedge, so this sees exactly what the next edge does.
    always @(negedge clk) begin
        if (rst || start_conv_pulse) begin
            sb.delete();
        end else begin
            if (input_req && fm_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop: got fm=%h with no word expected", fm);
                end else begin
                    logic [DW-1:0] exp_w;
                    exp_w = sb.pop_front();
                    if (fm !== exp_w) begin
                        n_fail++;
                        $display("FAIL sb_data: got fm=%h want %h", fm, exp_w);
                    end
                end
            end
            if (s_axis_tvalid && s_axis_tready) sb.push_back(s_axis_tdata);
        end
    end

    function automatic logic [DW-1:0] beat(input int i);
        return {16'hBEEF, frame_tag[15:0], i[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        frame_tag++;
        start_conv_pulse = 1'b1;
        cfg_frame_words  = 16'(n);
        tick();
        start_conv_pulse = 1'b0;
    endtask

    task automatic push_beats(input int first, input int count, input logic [31:0] mask);
        int idx;
        int waited;
        logic acc;
        idx = first;
        waited = 0;
        while (idx < first + count) begin
            s_axis_tdata  = beat(idx);
            s_axis_tlast  = mask[idx];
            s_axis_tvalid = 1'b1;
            acc = s_axis_tready;
            tick();
            if (acc) begin
                idx++;
                waited = 0;
            end else begin
                waited++;
                if (waited > 40) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL push_timeout: beat %0d got tready=0 want 1", idx);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pop_words(input int n);
        input_req = 1'b1;
        repeat (n) tick();
        input_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({s_axis_tready, fm_valid, frame_done, underflow_err, tlast_err} !== 5'b0 ||
            fifo_level !== 4'd0 || fm !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got tready=%b fm_valid=%b done=%b uf=%b tl=%b lvl=%0d fm=%h want all 0",
                     s_axis_tready, fm_valid, frame_done, underflow_err, tlast_err, fifo_level, fm);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tready: got %b want 0", s_axis_tready);
        end
    endtask

    task automatic test_basic_frame();
        start_frame(5);
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_tready_run: got %b want 1", s_axis_tready);
        end
        push_beats(0, 5, 32'h10);
        n_checks++;
        if (fifo_level !== 4'd5 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_full_frame: got lvl=%0d tready=%b want 5 0", fifo_level, s_axis_tready);
        end
        n_checks++;
        if (fm !== beat(0) || fm_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fwft: got fm=%h valid=%b want %h 1", fm, fm_valid, beat(0));
        end
        pop_words(5);
        n_checks++;
        if (frame_done !== 1'b1 || fifo_level !== 4'd0 || tlast_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b lvl=%0d tl=%b want 1 0 0", frame_done, fifo_level, tlast_err);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || fm !== '0 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got done=%b fm=%h tready=%b want 0 0 0", frame_done, fm, s_axis_tready);
        end
    endtask

    task automatic test_backpressure();
        start_frame(20);
        push_beats(0, 8, 32'h0);
        n_checks++;
        if (fifo_level !== 4'd8 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got lvl=%0d tready=%b want 8 0", fifo_level, s_axis_tready);
        end
        s_axis_tdata  = beat(8);
        s_axis_tvalid = 1'b1;
        repeat (3) tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd8 || fm !== beat(0)) begin
            n_fail++;
            $display("FAIL bp_ignored_beat: got lvl=%0d fm=%h want 8 %h", fifo_level, fm, beat(0));
        end
        pop_words(8);
        n_checks++;
        if (fifo_level !== 4'd0 || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got lvl=%0d tready=%b want 0 1", fifo_level, s_axis_tready);
        end
        push_beats(8, 8, 32'h0);
        n_checks++;
        if (fifo_level !== 4'd8 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full2: got lvl=%0d tready=%b want 8 0", fifo_level, s_axis_tready);
        end
        pop_words(8);
        push_beats(16, 4, 32'h8_0000);
        n_checks++;
        if (fifo_level !== 4'd4 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got lvl=%0d tready=%b want 4 0", fifo_level, s_axis_tready);
        end
        pop_words(4);
        n_checks++;
        if (frame_done !== 1'b1 || tlast_err !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b tl=%b left=%0d want 1 0 0", frame_done, tlast_err, sb.size());
        end
        tick();
    endtask

    task automatic test_simultaneous();
        start_frame(6);
        push_beats(0, 3, 32'h20);
        s_axis_tdata  = beat(3);
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        input_req     = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        input_req     = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd3 || fm !== beat(1)) begin
            n_fail++;
            $display("FAIL simul_level: got lvl=%0d fm=%h want 3 %h", fifo_level, fm, beat(1));
        end
        push_beats(4, 2, 32'h20);
        pop_words(5);
        n_checks++;
        if (frame_done !== 1'b1 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL simul_done: got done=%b lvl=%0d want 1 0", frame_done, fifo_level);
        end
        tick();
    endtask

    task automatic test_underflow();
        pop_words(1);
        n_checks++;
        if (underflow_err !== 1'b1 || fm !== '0 || fm_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL uf_idle: got uf=%b fm=%h valid=%b lvl=%0d want 1 0 0 0",
                     underflow_err, fm, fm_valid, fifo_level);
        end
        repeat (3) tick();
        n_checks++;
        if (underflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_sticky: got %b want 1", underflow_err);
        end
        start_frame(2);
        n_checks++;
        if (underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_clear: got %b want 0", underflow_err);
        end
        pop_words(1);
        n_checks++;
        if (underflow_err !== 1'b1 || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_run: got uf=%b tready=%b want 1 1", underflow_err, s_axis_tready);
        end
        push_beats(0, 2, 32'h2);
        pop_words(2);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_done: got %b want 1", frame_done);
        end
        tick();
    endtask

    task automatic test_tlast_err();
        start_frame(5);
        push_beats(0, 1, 32'h2);
        n_checks++;
        if (tlast_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tlast_ok_beat: got %b want 0", tlast_err);
        end
        push_beats(1, 1, 32'h2);
        n_checks++;
        if (tlast_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_early: got %b want 1", tlast_err);
        end
        push_beats(2, 3, 32'h2);
        n_checks++;
        if (fifo_level !== 4'd5 || tlast_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_buffered: got lvl=%0d tl=%b want 5 1", fifo_level, tlast_err);
        end
        pop_words(5);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_done: got %b want 1", frame_done);
        end
        tick();
    endtask

    task automatic test_abort();
        start_frame(10);
        push_beats(0, 4, 32'h0);
        n_checks++;
        if (fifo_level !== 4'd4) begin
            n_fail++;
            $display("FAIL abort_pre_level: got %0d want 4", fifo_level);
        end
        frame_tag++;
        start_conv_pulse = 1'b1;
        cfg_frame_words  = 16'd3;
        s_axis_tdata     = 64'hDEAD_DEAD_DEAD_DEAD;
        s_axis_tvalid    = 1'b1;
        input_req        = 1'b1;
        tick();
        start_conv_pulse = 1'b0;
        s_axis_tvalid    = 1'b0;
        input_req        = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd0 || fm_valid !== 1'b0 || frame_done !== 1'b0 ||
            s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flush: got lvl=%0d valid=%b done=%b tready=%b want 0 0 0 1",
                     fifo_level, fm_valid, frame_done, s_axis_tready);
        end
        push_beats(0, 3, 32'h4);
        n_checks++;
        if (fifo_level !== 4'd3 || fm !== beat(0)) begin
            n_fail++;
            $display("FAIL abort_new_frame: got lvl=%0d fm=%h want 3 %h", fifo_level, fm, beat(0));
        end
        pop_words(3);
        n_checks++;
        if (frame_done !== 1'b1 || tlast_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got done=%b tl=%b want 1 0", frame_done, tlast_err);
        end
        tick();
    endtask

    task automatic test_zero_frame();
        start_frame(0);
        n_checks++;
        if (frame_done !== 1'b1 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b tready=%b want 1 0", frame_done, s_axis_tready);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: got done=%b tready=%b want 0 0", frame_done, s_axis_tready);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(6);
        push_beats(0, 3, 32'h20);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (fifo_level !== 4'd0 || fm_valid !== 1'b0 || fm !== '0 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got lvl=%0d valid=%b fm=%h tready=%b want 0 0 0 0",
                     fifo_level, fm_valid, fm, s_axis_tready);
        end
        tick();
        rst = 1'b0;
        start_frame(2);
        push_beats(0, 2, 32'h2);
        pop_words(2);
        n_checks++;
        if (frame_done !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rst_restart: got done=%b left=%0d want 1 0", frame_done, sb.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_simultaneous();
        test_underflow();
        test_tlast_err();
        test_abort();
        test_zero_frame();
        test_reset_mid_frame();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d words want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
